// File: rtl/dmem_pkg.sv
// Shared decode constants for the data-memory responder: MMIO offsets, CTRL bit map,
// address-decode result and the byte-lane mask helper.
package dmem_pkg;

    localparam logic [4:0] OFF_GPIO  = 5'h00;
    localparam logic [4:0] OFF_COUNT = 5'h04;
    localparam logic [4:0] OFF_CMP   = 5'h08;
    localparam logic [4:0] OFF_CTRL  = 5'h0C;
    localparam logic [4:0] OFF_ID    = 5'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_MATCH  = 2;

    typedef enum logic [1:0] {
        HIT_RAM  = 2'd0,
        HIT_MMIO = 2'd1,
        HIT_NONE = 2'd2
    } hit_e;

    // Expand a 4-bit byte enable into a 32-bit bit mask
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running timer: COUNT, CMP and CTRL registers with compare-match flag.
// MATCH sets on the enabled edge at which COUNT takes the CMP value; set beats W1C.
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        count_wr,
    input  logic        cmp_wr,
    input  logic        ctrl_wr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] cmp,
    output logic [31:0] ctrl,
    output logic        irq
);

    logic [31:0] count_r;
    logic [31:0] cmp_r;
    logic [31:0] count_next_s;
    logic        en_r;
    logic        irq_en_r;
    logic        match_r;
    logic        match_set_s;
    logic        match_clr_s;

    // Next COUNT value: a software write overrides the enabled increment
    always_comb begin
        count_next_s = count_r;
        if (count_wr) begin
            count_next_s = wdata;
        end else if (en_r) begin
            count_next_s = count_r + 32'd1;
        end else begin
            count_next_s = count_r;
        end
    end

    assign match_set_s = en_r && (count_next_s == cmp_r);
    assign match_clr_s = ctrl_wr && wdata[CTRL_MATCH];

    // Timer register state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_r  <= 32'h0000_0000;
            cmp_r    <= 32'h0000_0000;
            en_r     <= 1'b0;
            irq_en_r <= 1'b0;
            match_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            if (cmp_wr) begin
                cmp_r <= wdata;
            end
            if (ctrl_wr) begin
                en_r     <= wdata[CTRL_EN];
                irq_en_r <= wdata[CTRL_IRQ_EN];
            end
            if (match_set_s) begin
                match_r <= 1'b1;
            end else if (match_clr_s) begin
                match_r <= 1'b0;
            end
        end
    end

    assign count = count_r;
    assign cmp   = cmp_r;
    assign ctrl  = {29'd0, match_r, irq_en_r, en_r};
    assign irq   = match_r & irq_en_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the single-cycle core: word RAM plus GPIO/timer/ID register window.
// Optional macro DMEM_BYTE_LANES_EN adds BYTE_EN[3:0] for partial RAM/GPIO stores.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter logic [31:0] ID_VALUE  = 32'h5256_0001
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] DIR_DMEM,
    input  logic [31:0] DATA_WRITE_DMEM,
    input  logic        READ,
    input  logic        WRITE,
    output logic [31:0] DATA_READ_DMEM,
    output logic [31:0] GPIO_OUT,
    output logic        TIMER_IRQ,
    output logic        BUS_ERR
`ifdef DMEM_BYTE_LANES_EN
    ,
    input  logic [3:0]  BYTE_EN
`endif
);

    localparam int          IDX_W     = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) << 2;

    logic [31:0]      ram_r [RAM_WORDS];
    logic [31:0]      gpio_r;
    logic             bus_err_r;
    hit_e             hit_s;
    logic [4:0]       off_s;
    logic [IDX_W-1:0] idx_s;
    logic [31:0]      wmask_s;
    logic             full_s;
    logic             ram_wr_s;
    logic             mmio_wr_s;
    logic             gpio_wr_s;
    logic             count_wr_s;
    logic             cmp_wr_s;
    logic             ctrl_wr_s;
    logic [31:0]      count_s;
    logic [31:0]      cmp_s;
    logic [31:0]      ctrl_s;
    logic             irq_s;
    logic [31:0]      rdata_s;

`ifdef DMEM_BYTE_LANES_EN
    assign wmask_s = lane_mask(BYTE_EN);
    assign full_s  = (BYTE_EN == 4'b1111);
`else
    assign wmask_s = 32'hFFFF_FFFF;
    assign full_s  = 1'b1;
`endif

    // Address decode: RAM window at zero, register window at MMIO_BASE, everything else unmapped
    always_comb begin
        hit_s = HIT_NONE;
        if ({1'b0, DIR_DMEM} < RAM_BYTES) begin
            hit_s = HIT_RAM;
        end else if (DIR_DMEM[31:5] == MMIO_BASE[31:5]) begin
            hit_s = HIT_MMIO;
        end else begin
            hit_s = HIT_NONE;
        end
    end

    assign idx_s = DIR_DMEM[IDX_W+1:2];
    assign off_s = {DIR_DMEM[4:2], 2'b00};

    // Partial stores to COUNT/CMP/CTRL are discarded; ID and reserved offsets get no strobe
    assign ram_wr_s   = WRITE && (hit_s == HIT_RAM);
    assign mmio_wr_s  = WRITE && (hit_s == HIT_MMIO);
    assign gpio_wr_s  = mmio_wr_s && (off_s == OFF_GPIO);
    assign count_wr_s = mmio_wr_s && full_s && (off_s == OFF_COUNT);
    assign cmp_wr_s   = mmio_wr_s && full_s && (off_s == OFF_CMP);
    assign ctrl_wr_s  = mmio_wr_s && full_s && (off_s == OFF_CTRL);

    // Data RAM store, lane-merged; contents are intentionally not reset
    always_ff @(posedge CLK) begin
        if (ram_wr_s) begin
            ram_r[idx_s] <= (ram_r[idx_s] & ~wmask_s) | (DATA_WRITE_DMEM & wmask_s);
        end
    end

    // GPIO register and sticky unmapped-access error
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            gpio_r    <= 32'h0000_0000;
            bus_err_r <= 1'b0;
        end else begin
            if (gpio_wr_s) begin
                gpio_r <= (gpio_r & ~wmask_s) | (DATA_WRITE_DMEM & wmask_s);
            end
            if ((READ || WRITE) && (hit_s == HIT_NONE)) begin
                bus_err_r <= 1'b1;
            end
        end
    end

    dmem_timer u_timer (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .count_wr (count_wr_s),
        .cmp_wr   (cmp_wr_s),
        .ctrl_wr  (ctrl_wr_s),
        .wdata    (DATA_WRITE_DMEM),
        .count    (count_s),
        .cmp      (cmp_s),
        .ctrl     (ctrl_s),
        .irq      (irq_s)
    );

    // Load data is combinational so the core can consume it in the same cycle
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (READ) begin
            case (hit_s)
                HIT_RAM: rdata_s = ram_r[idx_s];
                HIT_MMIO: begin
                    case (off_s)
                        OFF_GPIO:  rdata_s = gpio_r;
                        OFF_COUNT: rdata_s = count_s;
                        OFF_CMP:   rdata_s = cmp_s;
                        OFF_CTRL:  rdata_s = ctrl_s;
                        OFF_ID:    rdata_s = ID_VALUE;
                        default:   rdata_s = 32'h0000_0000;
                    endcase
                end
                default: rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign DATA_READ_DMEM = rdata_s;
    assign GPIO_OUT       = gpio_r;
    assign TIMER_IRQ      = irq_s;
    assign BUS_ERR        = bus_err_r;

endmodule
